// File: rtl/eq_pkg.sv
// Shared widths, types and Q15 arithmetic constants for the equalizer band FIR datapath.
package eq_pkg;
  localparam int DATA_WIDTH  = 16;
  localparam int COEFF_WIDTH = 16;
  localparam int ACC_WIDTH   = 40;
  localparam int TAP_COUNT   = 64;
  localparam int TAP_BITS    = 6;
  localparam int PROD_WIDTH  = DATA_WIDTH + COEFF_WIDTH;
  localparam int Q15_SHIFT   = 15;

  typedef logic signed [DATA_WIDTH-1:0]  sample_t;
  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
  typedef logic signed [PROD_WIDTH-1:0]  prod_t;
  typedef logic signed [ACC_WIDTH-1:0]   acc_t;
  typedef logic [TAP_BITS-1:0]           tap_t;

  localparam acc_t ROUND_CONST = acc_t'(64'sd1 <<< (Q15_SHIFT - 1));
  localparam acc_t SAT_MAX     = acc_t'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam acc_t SAT_MIN     = -SAT_MAX - acc_t'(1);

  typedef enum logic [1:0] {
    TAP_IDLE,
    TAP_FIRST,
    TAP_MID,
    TAP_LAST
  } tap_op_e;

  // Round half-up back to Q15 and clamp into the output sample range.
  function automatic sample_t round_sat(input acc_t value);
    acc_t scaled;
    scaled = (value + ROUND_CONST) >>> Q15_SHIFT;
    if (scaled > SAT_MAX) begin
      round_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      round_sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      round_sat = scaled[DATA_WIDTH-1:0];
    end
  endfunction
endpackage

// File: rtl/fir_tap_mac_if.sv
// Tap-sequencer, coefficient ROM and output bundle of one FIR band MAC.
interface fir_tap_mac_if;
  import eq_pkg::*;

  logic    clk_enable;
  tap_t    current_count;
  logic    phase_0;
  logic    phase_63;
  sample_t sample_in;
  tap_t    coeff_addr;
  coeff_t  coeff_in;
  sample_t filter_out;
  logic    out_valid;

  modport master (
    output clk_enable, current_count, phase_0, phase_63, sample_in, coeff_in,
    input  coeff_addr, filter_out, out_valid
  );

  modport slave (
    input  clk_enable, current_count, phase_0, phase_63, sample_in, coeff_in,
    output coeff_addr, filter_out, out_valid
  );
endinterface

// File: rtl/sample_ring_buffer.sv
// 64-entry sample history: written at frame start, pointer advanced at frame end.
module sample_ring_buffer
  import eq_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clk_enable,
  input  logic    phase_0,
  input  logic    phase_63,
  input  sample_t wr_data,
  input  tap_t    rd_tap,
  output sample_t rd_data
);

  sample_t slot_q [TAP_COUNT];
  sample_t slot_d [TAP_COUNT];
  tap_t    wr_ptr_q;
  tap_t    wr_ptr_d;
  tap_t    rd_idx;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    if (clk_enable && phase_0) begin
      slot_d[wr_ptr_q] = wr_data;
    end
    if (clk_enable && phase_63) begin
      wr_ptr_d = wr_ptr_q + tap_t'(1);
    end
  end

  // 6-bit subtraction gives the mod-64 wrap for free.
  assign rd_idx  = wr_ptr_q - rd_tap;
  assign rd_data = slot_q[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q   <= '{default: '0};
      wr_ptr_q <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/fir_tap_mac.sv
// Time-multiplexed 64-tap FIR MAC: one tap per enabled clock, one saturated Q15 sample per frame.
module fir_tap_mac
  import eq_pkg::*;
(
  input logic          clk,
  input logic          reset,
  fir_tap_mac_if.slave bus
);

  sample_t ring_data;
  sample_t tap_x;
  prod_t   prod_full;
  acc_t    product;
  acc_t    final_sum;
  acc_t    acc_q, acc_d;
  sample_t filter_out_q, filter_out_d;
  logic    out_valid_q, out_valid_d;
  logic    started_q, started_d;
  tap_op_e tap_op;

  sample_ring_buffer u_ring (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (bus.clk_enable),
    .phase_0    (bus.phase_0),
    .phase_63   (bus.phase_63),
    .wr_data    (bus.sample_in),
    .rd_tap     (bus.current_count),
    .rd_data    (ring_data)
  );

  assign bus.coeff_addr = bus.current_count;

  // Tap 0 is the sample arriving this frame, so it bypasses the history.
  assign tap_x     = (bus.current_count == '0) ? bus.sample_in : ring_data;
  assign prod_full = tap_x * bus.coeff_in;
  assign product   = acc_t'(prod_full);

  always_comb begin
    tap_op = TAP_IDLE;
    if (bus.clk_enable) begin
      if (bus.phase_0) begin
        tap_op = TAP_FIRST;
      end else if (bus.phase_63) begin
        tap_op = TAP_LAST;
      end else begin
        tap_op = TAP_MID;
      end
    end
  end

  always_comb begin
    final_sum    = acc_q + product;
    acc_d        = acc_q;
    started_d    = started_q;
    filter_out_d = filter_out_q;
    out_valid_d  = 1'b0;
    case (tap_op)
      TAP_FIRST: begin
        acc_d     = product;
        started_d = 1'b1;
      end
      TAP_MID: begin
        acc_d = final_sum;
      end
      TAP_LAST: begin
        acc_d        = final_sum;
        filter_out_d = round_sat(final_sum);
        out_valid_d  = started_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      started_q    <= 1'b0;
      filter_out_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      started_q    <= started_d;
      filter_out_q <= filter_out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.filter_out = filter_out_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed and randomized frames against a convolution-level model of the band FIR.
module tb_fir_tap_mac;
  import eq_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fir_tap_mac_if bus ();

  fir_tap_mac dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic signed [15:0] coeff_rom [64];
  assign bus.coeff_in = coeff_rom[bus.coeff_addr];

  int checks = 0;
  int errors = 0;

  // hist[j] is the sample committed j+1 frames ago.
  longint             hist [64];
  longint             carry;
  bit                 started_m;
  logic signed [15:0] exp_out;
  logic               exp_valid;
  logic signed [15:0] outs [$];

  function automatic logic signed [15:0] ref_round_sat(input longint v);
    longint r;
    r = (v + 64'sd16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_cycle(input string tag);
    check_output({tag, "_valid"}, 16'(bus.out_valid), 16'(exp_valid));
    check_output({tag, "_out"}, bus.filter_out, exp_out);
  endtask

  task automatic apply_stimulus(input bit en, input int k, input bit p0, input bit p63,
                                input logic signed [15:0] s);
    @(negedge clk);
    bus.clk_enable    = en;
    bus.current_count = 6'(k);
    bus.phase_0       = p0;
    bus.phase_63      = p63;
    bus.sample_in     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset             = 1'b1;
    bus.clk_enable    = 1'b1;
    bus.current_count = 6'd0;
    bus.phase_0       = 1'b1;
    bus.phase_63      = 1'b0;
    bus.sample_in     = 16'($urandom);
    @(posedge clk);
    #1;
    for (int j = 0; j < 64; j++) hist[j] = 0;
    carry     = 0;
    started_m = 1'b0;
    exp_out   = '0;
    exp_valid = 1'b0;
    check_cycle("reset");
    @(negedge clk);
    reset          = 1'b0;
    bus.clk_enable = 1'b0;
    @(posedge clk);
    #1;
    check_cycle("post_reset");
  endtask

  task automatic run_frame(input logic signed [15:0] s, input int start_k, input int end_k,
                           input bit has_p0, input bit has_p63, input int gap_pct);
    longint acc_m;
    longint x;
    bit     p0;
    bit     p63;
    acc_m = carry;
    for (int k = start_k; k <= end_k; k++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        apply_stimulus(1'b0, k, k == 0, k == 63, 16'($urandom));
        exp_valid = 1'b0;
        check_cycle("idle");
      end
      p0  = has_p0 && (k == 0);
      p63 = has_p63 && (k == 63);
      x   = (k == 0) ? longint'(s) : hist[k-1];
      if (p0) acc_m = x * longint'(coeff_rom[k]);
      else    acc_m = acc_m + x * longint'(coeff_rom[k]);
      apply_stimulus(1'b1, k, p0, p63, s);
      if (p63) begin
        exp_out   = ref_round_sat(acc_m);
        exp_valid = started_m;
      end else begin
        exp_valid = 1'b0;
      end
      if (p0) started_m = 1'b1;
      check_cycle(p63 ? "frame_end" : "tap");
      check_output("coeff_addr", 16'(bus.coeff_addr), 16'(k));
      if (bus.out_valid === 1'b1) outs.push_back(bus.filter_out);
    end
    carry = acc_m;
    if (has_p63) begin
      x = has_p0 ? longint'(s) : hist[63];
      for (int j = 63; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = x;
    end else if (has_p0) begin
      hist[63] = s;
    end
  endtask

  task automatic check_dc_outs(input string tag);
    check_output({tag, "_count"}, 16'(outs.size()), 16'd70);
    for (int n = 0; n < outs.size(); n++) begin
      check_output(tag, outs[n], (n < 64) ? 16'(500 * (n + 1)) : 16'd32000);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus.clk_enable    = 1'b0;
    bus.current_count = '0;
    bus.phase_0       = 1'b0;
    bus.phase_63      = 1'b0;
    bus.sample_in     = '0;
    for (int k = 0; k < 64; k++) coeff_rom[k] = 16'sd16384;
    do_reset();

    $display("[TB] DC response, no gaps");
    outs.delete();
    for (int f = 0; f < 70; f++) run_frame(16'sd1000, 0, 63, 1'b1, 1'b1, 0);
    check_dc_outs("dc");

    $display("[TB] DC response with enable gaps");
    do_reset();
    outs.delete();
    for (int f = 0; f < 70; f++) run_frame(16'sd1000, 0, 63, 1'b1, 1'b1, 40);
    check_dc_outs("dc_gap");

    $display("[TB] Impulse response and ring wrap");
    do_reset();
    for (int k = 0; k < 64; k++) coeff_rom[k] = 16'(100 * k);
    outs.delete();
    run_frame(16'sd32767, 0, 63, 1'b1, 1'b1, 0);
    for (int f = 1; f < 66; f++) run_frame(16'sd0, 0, 63, 1'b1, 1'b1, 0);
    check_output("imp_count", 16'(outs.size()), 16'd66);
    for (int n = 0; n < outs.size(); n++) begin
      check_output("imp", outs[n], (n < 64) ? 16'(100 * n) : 16'd0);
    end

    $display("[TB] Saturation");
    for (int k = 0; k < 64; k++) coeff_rom[k] = 16'sd32767;
    do_reset();
    outs.delete();
    for (int f = 0; f < 2; f++) run_frame(16'sd32767, 0, 63, 1'b1, 1'b1, 0);
    check_output("sat_pos_count", 16'(outs.size()), 16'd2);
    if (outs.size() == 2) check_output("sat_pos", outs[1], 16'sd32767);
    do_reset();
    outs.delete();
    for (int f = 0; f < 2; f++) run_frame(-16'sd32768, 0, 63, 1'b1, 1'b1, 0);
    check_output("sat_neg_count", 16'(outs.size()), 16'd2);
    if (outs.size() == 2) check_output("sat_neg", outs[1], -16'sd32768);

    $display("[TB] Reset mid-frame");
    for (int k = 0; k < 64; k++) coeff_rom[k] = 16'sd16384;
    do_reset();
    for (int f = 0; f < 5; f++) run_frame(16'sd1000, 0, 63, 1'b1, 1'b1, 0);
    run_frame(16'sd1000, 0, 30, 1'b1, 1'b0, 0);
    do_reset();
    outs.delete();
    run_frame(16'sd1000, 40, 63, 1'b0, 1'b1, 0);
    check_output("rst_partial_count", 16'(outs.size()), 16'd0);
    run_frame(16'sd1000, 0, 63, 1'b1, 1'b1, 0);
    check_output("rst_full_count", 16'(outs.size()), 16'd1);
    if (outs.size() == 1) check_output("rst_full", outs[0], 16'sd500);

    $display("[TB] Missing start");
    do_reset();
    outs.delete();
    run_frame(16'sd1000, 0, 63, 1'b0, 1'b0, 0);
    run_frame(16'sd2000, 0, 63, 1'b0, 1'b1, 0);
    check_output("nostart_valid", 16'(bus.out_valid), 16'd0);
    check_output("nostart_carry", bus.filter_out, 16'sd1500);
    run_frame(16'sd4000, 0, 63, 1'b1, 1'b1, 0);
    check_output("reload_count", 16'(outs.size()), 16'd1);
    if (outs.size() == 1) check_output("reload", outs[0], 16'sd2000);

    $display("[TB] Random coefficients and samples with gaps");
    do_reset();
    for (int k = 0; k < 64; k++) coeff_rom[k] = 16'($urandom);
    for (int f = 0; f < 12; f++) begin
      run_frame(16'($urandom), 0, 63, 1'b1, f != 4, 30);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
